// File: rtl/motor_ramp_ctrl.sv
// Command stage ahead of motor_controller: slews duty toward the commanded target once per
// prescaler tick, inserts a zero-duty dead time on reversal, and lets estop override everything.
module motor_ramp_ctrl #(
    parameter int DUTY_W     = 10,
    parameter int STEP_DIV   = 50000,
    parameter int STEP       = 4,
    parameter int DEAD_TICKS = 100
) (
    input  logic              CLOCK_50,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_dir,
    input  logic [DUTY_W-1:0] cmd_duty,
    input  logic              estop,
    output logic              direction,
    output logic              enable,
    output logic [DUTY_W-1:0] duty,
    output logic              at_target,
    output logic              busy
);

    localparam int EW = DUTY_W + 1;
    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam int CW = (DEAD_TICKS > 1) ? $clog2(DEAD_TICKS + 1) : 1;

    localparam logic [EW-1:0]     STEP_E     = EW'(STEP);
    localparam logic [EW-1:0]     DUTY_MAX_E = {1'b0, {DUTY_W{1'b1}}};
    localparam logic [DUTY_W-1:0] DUTY_ZERO  = {DUTY_W{1'b0}};
    localparam logic [PW-1:0]     PRESC_LAST = PW'(STEP_DIV - 1);
    localparam logic [PW-1:0]     PRESC_ZERO = {PW{1'b0}};
    localparam logic [PW-1:0]     PRESC_ONE  = PW'(1);
    localparam logic [CW-1:0]     DEAD_LAST  = CW'(DEAD_TICKS - 1);
    localparam logic [CW-1:0]     DEAD_ZERO  = {CW{1'b0}};
    localparam logic [CW-1:0]     DEAD_ONE   = CW'(1);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_RAMP      = 3'd1,
        ST_HOLD      = 3'd2,
        ST_DECEL_REV = 3'd3,
        ST_DEAD      = 3'd4,
        ST_ESTOP     = 3'd5
    } state_t;

    state_t            state_r;
    state_t            state_next_s;
    logic [PW-1:0]     presc_r;
    logic [CW-1:0]     dead_cnt_r;
    logic              target_dir_r;
    logic [DUTY_W-1:0] target_duty_r;
    logic [DUTY_W-1:0] duty_r;
    logic              direction_r;
    logic              enable_r;
    logic              cmd_ready_r;
    logic              at_target_r;
    logic              busy_r;

    logic              tick_s;
    logic              accept_s;
    logic              dir_match_s;
    logic              dead_done_s;
    logic [EW-1:0]     duty_e_s;
    logic [EW-1:0]     tgt_e_s;
    logic [EW-1:0]     up_sum_s;
    logic [DUTY_W-1:0] up_s;
    logic [DUTY_W-1:0] dn_tgt_s;
    logic [DUTY_W-1:0] dn_zero_s;
    logic [DUTY_W-1:0] ramp_duty_s;
    logic [DUTY_W-1:0] decel_duty_s;

    logic [DUTY_W-1:0] duty_next_s;
    logic              direction_next_s;
    logic [CW-1:0]     dead_next_s;
    logic              tdir_next_s;
    logic [DUTY_W-1:0] tduty_next_s;
    logic              enable_next_s;
    logic              ready_next_s;
    logic              at_target_next_s;
    logic              busy_next_s;

    assign tick_s      = (presc_r == PRESC_LAST);
    assign accept_s    = cmd_valid & cmd_ready_r;
    assign dir_match_s = (target_dir_r == direction_r);
    assign dead_done_s = tick_s & (dead_cnt_r == DEAD_LAST);

    // Free-running ramp prescaler, independent of state.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            presc_r <= PRESC_ZERO;
        end else if (tick_s) begin
            presc_r <= PRESC_ZERO;
        end else begin
            presc_r <= presc_r + PRESC_ONE;
        end
    end

    // Saturating step candidates computed one bit wider so neither direction can wrap.
    always_comb begin
        duty_e_s = {1'b0, duty_r};
        tgt_e_s  = {1'b0, target_duty_r};
        up_sum_s = duty_e_s + STEP_E;
        if (up_sum_s > tgt_e_s) begin
            up_s = target_duty_r;
        end else if (up_sum_s > DUTY_MAX_E) begin
            up_s = DUTY_W'(DUTY_MAX_E);
        end else begin
            up_s = DUTY_W'(up_sum_s);
        end
        if (duty_e_s < (tgt_e_s + STEP_E)) begin
            dn_tgt_s = target_duty_r;
        end else begin
            dn_tgt_s = DUTY_W'(duty_e_s - STEP_E);
        end
        if (duty_e_s < STEP_E) begin
            dn_zero_s = DUTY_ZERO;
        end else begin
            dn_zero_s = DUTY_W'(duty_e_s - STEP_E);
        end
        if (!tick_s) begin
            ramp_duty_s = duty_r;
        end else if (target_duty_r > duty_r) begin
            ramp_duty_s = up_s;
        end else begin
            ramp_duty_s = dn_tgt_s;
        end
        if (tick_s) begin
            decel_duty_s = dn_zero_s;
        end else begin
            decel_duty_s = duty_r;
        end
    end

    // State register.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic; transitions use the target latched before this edge.
    always_comb begin
        state_next_s = state_r;
        if (estop) begin
            state_next_s = ST_ESTOP;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (target_duty_r == DUTY_ZERO) begin
                        state_next_s = ST_IDLE;
                    end else if (dir_match_s) begin
                        state_next_s = ST_RAMP;
                    end else begin
                        state_next_s = ST_DEAD;
                    end
                end
                ST_RAMP: begin
                    if (!dir_match_s) begin
                        state_next_s = ST_DECEL_REV;
                    end else if (ramp_duty_s != target_duty_r) begin
                        state_next_s = ST_RAMP;
                    end else if (ramp_duty_s != DUTY_ZERO) begin
                        state_next_s = ST_HOLD;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (!dir_match_s) begin
                        state_next_s = ST_DECEL_REV;
                    end else if (target_duty_r != duty_r) begin
                        state_next_s = ST_RAMP;
                    end else begin
                        state_next_s = ST_HOLD;
                    end
                end
                ST_DECEL_REV: begin
                    if (dir_match_s) begin
                        state_next_s = ST_RAMP;
                    end else if (decel_duty_s == DUTY_ZERO) begin
                        state_next_s = ST_DEAD;
                    end else begin
                        state_next_s = ST_DECEL_REV;
                    end
                end
                ST_DEAD: begin
                    if (!dead_done_s) begin
                        state_next_s = ST_DEAD;
                    end else if (target_duty_r != DUTY_ZERO) begin
                        state_next_s = ST_RAMP;
                    end else begin
                        state_next_s = ST_IDLE;
                    end
                end
                ST_ESTOP: begin
                    state_next_s = ST_IDLE;
                end
                default: begin
                    state_next_s = ST_IDLE;
                end
            endcase
        end
    end

    // Datapath next values; status flags are derived from the post-edge values so they stay registered.
    always_comb begin
        duty_next_s      = duty_r;
        direction_next_s = direction_r;
        dead_next_s      = dead_cnt_r;
        tdir_next_s      = target_dir_r;
        tduty_next_s     = target_duty_r;
        if (estop) begin
            duty_next_s  = DUTY_ZERO;
            tduty_next_s = DUTY_ZERO;
            dead_next_s  = DEAD_ZERO;
        end else begin
            if (accept_s) begin
                tdir_next_s  = cmd_dir;
                tduty_next_s = cmd_duty;
            end else begin
                tdir_next_s  = target_dir_r;
                tduty_next_s = target_duty_r;
            end
            case (state_r)
                ST_RAMP: begin
                    dead_next_s = DEAD_ZERO;
                    if (dir_match_s) begin
                        duty_next_s = ramp_duty_s;
                    end else begin
                        duty_next_s = duty_r;
                    end
                end
                ST_HOLD: begin
                    dead_next_s = DEAD_ZERO;
                    duty_next_s = duty_r;
                end
                ST_DECEL_REV: begin
                    dead_next_s = DEAD_ZERO;
                    if (dir_match_s) begin
                        duty_next_s = duty_r;
                    end else begin
                        duty_next_s = decel_duty_s;
                    end
                end
                ST_DEAD: begin
                    duty_next_s = DUTY_ZERO;
                    if (dead_done_s) begin
                        direction_next_s = target_dir_r;
                        dead_next_s      = DEAD_ZERO;
                    end else if (tick_s) begin
                        dead_next_s = dead_cnt_r + DEAD_ONE;
                    end else begin
                        dead_next_s = dead_cnt_r;
                    end
                end
                default: begin
                    duty_next_s = DUTY_ZERO;
                    dead_next_s = DEAD_ZERO;
                end
            endcase
        end
        enable_next_s    = (duty_next_s != DUTY_ZERO);
        ready_next_s     = (state_next_s != ST_ESTOP);
        busy_next_s      = (state_next_s == ST_RAMP) || (state_next_s == ST_DECEL_REV) ||
                           (state_next_s == ST_DEAD);
        at_target_next_s = (duty_next_s == tduty_next_s) &&
                           ((direction_next_s == tdir_next_s) || (tduty_next_s == DUTY_ZERO)) &&
                           (state_next_s != ST_DEAD) && (state_next_s != ST_DECEL_REV);
    end

    // Datapath and output registers.
    always_ff @(posedge CLOCK_50 or negedge reset_n) begin
        if (!reset_n) begin
            duty_r        <= DUTY_ZERO;
            direction_r   <= 1'b1;
            enable_r      <= 1'b0;
            dead_cnt_r    <= DEAD_ZERO;
            target_dir_r  <= 1'b1;
            target_duty_r <= DUTY_ZERO;
            cmd_ready_r   <= 1'b0;
            at_target_r   <= 1'b1;
            busy_r        <= 1'b0;
        end else begin
            duty_r        <= duty_next_s;
            direction_r   <= direction_next_s;
            enable_r      <= enable_next_s;
            dead_cnt_r    <= dead_next_s;
            target_dir_r  <= tdir_next_s;
            target_duty_r <= tduty_next_s;
            cmd_ready_r   <= ready_next_s;
            at_target_r   <= at_target_next_s;
            busy_r        <= busy_next_s;
        end
    end

    assign duty      = duty_r;
    assign direction = direction_r;
    assign enable    = enable_r;
    assign cmd_ready = cmd_ready_r;
    assign at_target = at_target_r;
    assign busy      = busy_r;

endmodule

// File: tb/tb_motor_ramp_ctrl.sv
// Bench for motor_ramp_ctrl: directed scenarios plus randomized commands, every cycle compared
// against a behavioural model built from the ramp/reversal/estop rules.
module tb_motor_ramp_ctrl;

    localparam int DUTY_W     = 10;
    localparam int STEP_DIV   = 4;
    localparam int STEP       = 4;
    localparam int DEAD_TICKS = 2;
    localparam int DUTY_MAX   = (1 << DUTY_W) - 1;

    localparam int MD_IDLE  = 0;
    localparam int MD_RAMP  = 1;
    localparam int MD_HOLD  = 2;
    localparam int MD_DECEL = 3;
    localparam int MD_DEAD  = 4;
    localparam int MD_ESTOP = 5;

    logic              CLOCK_50 = 1'b0;
    logic              reset_n;
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_dir;
    logic [DUTY_W-1:0] cmd_duty;
    logic              estop;
    logic              direction;
    logic              enable;
    logic [DUTY_W-1:0] duty;
    logic              at_target;
    logic              busy;

    int n_vec;
    int n_bad;
    int m_mode, m_duty, m_dir, m_tdir, m_tduty, m_presc, m_dead, m_ready, m_acc;
    int r_sel, r_duty;

    motor_ramp_ctrl #(
        .DUTY_W(DUTY_W), .STEP_DIV(STEP_DIV), .STEP(STEP), .DEAD_TICKS(DEAD_TICKS)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_dir(cmd_dir), .cmd_duty(cmd_duty), .estop(estop), .direction(direction),
        .enable(enable), .duty(duty), .at_target(at_target), .busy(busy)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input int obs, input int exp);
        n_vec++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: observed %0d expected %0d at t=%0t", tag, obs, exp, $time);
        end
    endtask

    // One saturating ramp step from cur toward tgt.
    function automatic int approach(input int cur, input int tgt);
        int r;
        if (cur < tgt) begin
            r = cur + STEP;
            if (r > tgt) r = tgt;
            if (r > DUTY_MAX) r = DUTY_MAX;
        end else begin
            r = cur - STEP;
            if (r < tgt) r = tgt;
        end
        return r;
    endfunction

    task automatic model_reset();
        m_mode = MD_IDLE; m_duty = 0; m_dir = 1; m_tdir = 1; m_tduty = 0;
        m_presc = 0; m_dead = 0; m_ready = 0; m_acc = 0;
    endtask

    task automatic model_step();
        bit tick;
        if (!reset_n) begin
            model_reset();
            return;
        end
        tick = (m_presc == STEP_DIV - 1);
        m_acc = (cmd_valid && m_ready != 0) ? 1 : 0;
        m_presc = tick ? 0 : m_presc + 1;
        if (estop) begin
            m_mode = MD_ESTOP; m_duty = 0; m_tduty = 0; m_dead = 0; m_ready = 0; m_acc = 0;
            return;
        end
        case (m_mode)
            MD_IDLE: begin
                if (m_tduty != 0) m_mode = (m_tdir == m_dir) ? MD_RAMP : MD_DEAD;
            end
            MD_RAMP: begin
                if (m_tdir != m_dir) begin
                    m_mode = MD_DECEL;
                end else begin
                    if (tick) m_duty = approach(m_duty, m_tduty);
                    if (m_duty == m_tduty) m_mode = (m_duty != 0) ? MD_HOLD : MD_IDLE;
                end
            end
            MD_HOLD: begin
                if (m_tdir != m_dir) m_mode = MD_DECEL;
                else if (m_tduty != m_duty) m_mode = MD_RAMP;
            end
            MD_DECEL: begin
                if (m_tdir == m_dir) begin
                    m_mode = MD_RAMP;
                end else begin
                    if (tick) m_duty = approach(m_duty, 0);
                    if (m_duty == 0) begin m_mode = MD_DEAD; m_dead = 0; end
                end
            end
            MD_DEAD: begin
                if (tick) begin
                    m_dead++;
                    if (m_dead == DEAD_TICKS) begin
                        m_dir = m_tdir; m_dead = 0;
                        m_mode = (m_tduty != 0) ? MD_RAMP : MD_IDLE;
                    end
                end
            end
            default: m_mode = MD_IDLE;
        endcase
        if (m_acc != 0) begin
            m_tdir = int'(cmd_dir); m_tduty = int'(cmd_duty);
        end
        m_ready = 1;
    endtask

    task automatic compare_all();
        int at_exp, busy_exp;
        busy_exp = (m_mode == MD_RAMP || m_mode == MD_DECEL || m_mode == MD_DEAD) ? 1 : 0;
        at_exp = (m_duty == m_tduty && (m_dir == m_tdir || m_tduty == 0) &&
                  m_mode != MD_DEAD && m_mode != MD_DECEL) ? 1 : 0;
        chk("duty", int'(duty), m_duty);
        chk("enable", int'(enable), (m_duty != 0) ? 1 : 0);
        chk("direction", int'(direction), m_dir);
        chk("cmd_ready", int'(cmd_ready), m_ready);
        chk("busy", int'(busy), busy_exp);
        chk("at_target", int'(at_target), at_exp);
    endtask

    task automatic step();
        @(posedge CLOCK_50);
        model_step();
        @(negedge CLOCK_50);
        compare_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic send(input int dir, input int dty);
        cmd_dir = dir[0];
        cmd_duty = dty[DUTY_W-1:0];
        cmd_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (m_acc != 0) break;
        end
        cmd_valid = 1'b0;
    endtask

    task automatic wait_duty(input string tag, input int tgt, input int limit);
        for (int i = 0; i < limit; i++) begin
            if (int'(duty) == tgt) break;
            step();
        end
        chk(tag, int'(duty), tgt);
    endtask

    initial begin
        n_vec = 0; n_bad = 0;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_dir = 1'b1; cmd_duty = '0; estop = 1'b0;
        model_reset();
        repeat (2) @(negedge CLOCK_50);
        compare_all();
        reset_n = 1'b1;

        // Ramp up to 100 and settle in HOLD.
        send(1, 100);
        run(110);
        chk("hold_duty", int'(duty), 100);
        chk("hold_at_target", int'(at_target), 1);
        chk("hold_busy", int'(busy), 0);

        // Saturation at the top and clean stop just above zero.
        send(1, 1020);
        wait_duty("reach_1020", 1020, 1000);
        send(1, 1023);
        run(5);
        chk("sat_1023", int'(duty), 1023);
        send(1, 2);
        wait_duty("floor_2", 2, 1100);
        run(8);
        chk("no_underflow", int'(duty), 2);

        // Full reversal fwd/100 -> rev/50.
        send(1, 100);
        wait_duty("rev_pre", 100, 500);
        run(2);
        send(0, 50);
        wait_duty("rev_zero", 0, 120);
        chk("rev_enable_off", int'(enable), 0);
        run(12);
        chk("rev_dir", int'(direction), 0);
        wait_duty("rev_50", 50, 80);

        // Reversal aborted mid-deceleration.
        send(1, 100);
        wait_duty("abort_pre", 100, 300);
        chk("abort_pre_dir", int'(direction), 1);
        send(0, 50);
        wait_duty("abort_60", 60, 80);
        send(1, 80);
        wait_duty("abort_80", 80, 60);
        chk("abort_dir", int'(direction), 1);

        // Estop mid-ramp with a command pending.
        send(1, 10);
        wait_duty("estop_pre", 40, 200);
        estop = 1'b1; cmd_valid = 1'b1; cmd_dir = 1'b1; cmd_duty = 10'd500;
        step();
        chk("estop_duty", int'(duty), 0);
        chk("estop_enable", int'(enable), 0);
        chk("estop_ready", int'(cmd_ready), 0);
        step();
        estop = 1'b0; cmd_valid = 1'b0;
        step();
        chk("estop_release_ready", int'(cmd_ready), 1);
        run(12);
        chk("estop_target_zero", int'(duty), 0);

        // Asynchronous reset between edges, then a command landing on a tick edge.
        send(1, 200);
        run(20);
        #2 reset_n = 1'b0;
        #1;
        chk("async_duty", int'(duty), 0);
        chk("async_enable", int'(enable), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_dir", int'(direction), 1);
        model_reset();
        run(2);
        reset_n = 1'b1;
        step();
        for (int i = 0; i < 8; i++) begin
            if (m_presc == STEP_DIV - 1) break;
            step();
        end
        send(1, 30);
        chk("tick_old_target", int'(duty), 0);
        run(4);
        chk("tick_new_target", int'(duty), 4);

        // Randomized commands with occasional estop bursts.
        for (int i = 0; i < 250; i++) begin
            r_sel = $urandom_range(0, 15);
            if (r_sel == 0) begin
                estop = 1'b1;
                cmd_valid = 1'($urandom_range(0, 1));
                cmd_dir = 1'($urandom_range(0, 1));
                cmd_duty = 10'($urandom_range(0, DUTY_MAX));
                run($urandom_range(1, 3));
                estop = 1'b0;
                cmd_valid = 1'b0;
                step();
            end else begin
                case ($urandom_range(0, 3))
                    0: r_duty = 0;
                    1: r_duty = DUTY_MAX - $urandom_range(0, 3);
                    2: r_duty = $urandom_range(0, 40);
                    default: r_duty = $urandom_range(0, DUTY_MAX);
                endcase
                send($urandom_range(0, 1), r_duty);
                run($urandom_range(0, 80));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/motor_ramp_ctrl.md
Name: motor_ramp_ctrl

Overview:
- Upstream command stage for motor_controller.
- Accepts speed commands (direction + 10-bit duty) over a valid/ready handshake.
- Drives the direction, enable and duty inputs of one motor_controller instance.
- Slews duty toward the commanded target at a fixed rate; on a reversal it ramps to zero and waits a dead time before flipping direction. Emergency stop overrides everything.

Parameters:
- DUTY_W, 10: duty width; matches the motor_controller duty input.
- STEP_DIV, 50000: CLOCK_50 cycles per ramp tick (1 kHz at 50 MHz).
- STEP, 4: duty change per tick.
- DEAD_TICKS, 100: ticks held at zero duty before a direction flip.

Ports:
- CLOCK_50  in  1  system clock; all logic on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready at a rising edge.
- cmd_dir  in  1  requested direction (1 = forward).
- cmd_duty  in  DUTY_W  requested duty magnitude.
- estop  in  1  emergency stop, level-sensitive, synchronous sample.
- direction  out  1  to motor_controller direction input.
- enable  out  1  to motor_controller enable input.
- duty  out  DUTY_W  to motor_controller duty input.
- at_target  out  1  duty and direction equal the latched target.
- busy  out  1  ramp or reversal in progress.

Behaviour:
- Reset (reset_n low, takes effect without a clock edge):
  - duty=0, enable=0, direction=1, cmd_ready=0, at_target=1, busy=0.
  - state=IDLE, target_dir=1, target_duty=0, prescaler=0, dead counter=0.
  - cmd_ready rises on the first edge after release.
- Prescaler:
  - Counts 0..STEP_DIV-1 and wraps; tick is a 1-cycle pulse when count==STEP_DIV-1.
  - Free-running in every state. Duty changes only on tick edges, except ESTOP.
- Commands:
  - cmd_ready=1 in all states except ESTOP.
  - On acceptance, target_dir and target_duty are latched; the ramp retargets from the current duty.
  - A command accepted on the same edge as a tick: that tick uses the old target; the new target applies from the next tick.
- Ramp arithmetic (DUTY_W+1 bits, saturating):
  - up: duty = min(duty+STEP, target_duty, 2^DUTY_W-1)
  - down: duty = max(duty-STEP, floor), where floor is target_duty in RAMP and 0 in DECEL_REV.
  - No wrap-around in either direction.
- enable is registered and equals (duty_next != 0); it is never 1 while duty==0.
- direction changes only on the DEAD->RAMP transition, when duty==0.
- States and transitions:
  - IDLE: duty==0.
    - target_duty!=0 and target_dir==direction -> RAMP.
    - target_duty!=0 and target_dir!=direction -> DEAD.
  - RAMP: step toward target_duty on each tick.
    - target_dir!=direction -> DECEL_REV.
    - duty==target_duty and duty!=0 -> HOLD.
    - duty==target_duty==0 -> IDLE.
  - HOLD: duty constant.
    - A new target with different duty -> RAMP.
    - A new target with different dir -> DECEL_REV.
  - DECEL_REV: step down toward 0 on each tick.
    - target_dir returns to equal direction -> RAMP (no stop).
    - duty reaches 0 -> DEAD, dead counter cleared.
  - DEAD: duty=0, enable=0; dead counter increments per tick.
    - On reaching DEAD_TICKS: direction <= target_dir, dead counter cleared.
    - Then -> RAMP if target_duty!=0, else IDLE.
    - Commands accepted during DEAD update the target only; the dead time always completes.
  - ESTOP: entered from any state on the edge where estop==1.
    - Same edge: duty=0, enable=0, target_duty=0, cmd_ready=0.
    - direction is held; the dead counter is cleared.
    - Commands are ignored; the state holds while estop==1.
    - First edge with estop==0 -> IDLE, cmd_ready=1.
- busy = state in {RAMP, DECEL_REV, DEAD}.
- at_target = (duty==target_duty) & (direction==target_dir | target_duty==0) & state not in {DEAD, DECEL_REV}.
- Outputs are registered. Command-to-first-duty-change latency: at most STEP_DIV cycles (the next tick).

Test Plan:
Bench overrides: STEP_DIV=4, STEP=4, DEAD_TICKS=2.
- Reset, then cmd fwd/100 -> duty rises 4 per tick (every 4 cycles); enable=1 after the first tick; duty=100 after 25 ticks; then HOLD, at_target=1, busy=0.
- Ramp at 1020, cmd fwd/1023 -> next tick duty=1023 (saturates, no wrap); cmd fwd/2 from 1023 -> ramps down and stops exactly at 2, no underflow.
- Reversal: HOLD fwd/100, cmd rev/50 -> 25 ticks down to 0, enable=0, 2 dead ticks, direction=0, then 13 ticks to 50 (last step clipped 48->50).
- Reversal abort: in DECEL_REV at duty 60, cmd fwd/80 -> RAMP without reaching 0; direction stays 1; duty reaches 80.
- estop pulse mid-ramp (duty 40) -> next edge duty=0, enable=0, cmd_ready=0, cmd_valid ignored; on release -> IDLE, cmd_ready=1, target_duty=0.
- reset_n low between edges mid-ramp -> duty, enable and busy are 0 immediately with no clock edge; direction=1; after release, a cmd coincident with a tick takes effect from the following tick.
